// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM state type and byte-classification helpers
// used by the message assembler and its byte classifier.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } midi_state_e;

  typedef struct packed {
    logic       is_data;
    logic       is_chan;
    logic       is_common;
    logic       is_rt;
    logic [1:0] data_len;
  } midi_class_t;

  // Number of data bytes following a status byte; 0 for data/realtime/others.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_status_class.sv
// Combinational classifier: splits a received byte into the four MIDI
// byte classes and reports how many data bytes its message carries.
module midi_status_class
  import midi_pkg::*;
(
  input  logic [7:0]  rx_byte_i,
  output midi_class_t class_o
);

  // Decode the byte class from the top bits.
  always_comb begin
    class_o           = '0;
    class_o.is_data   = ~rx_byte_i[7];
    class_o.is_chan   = rx_byte_i[7] & (rx_byte_i[7:4] != 4'hF);
    class_o.is_common = (rx_byte_i[7:3] == 5'b11110);
    class_o.is_rt     = (rx_byte_i[7:3] == 5'b11111);
    class_o.data_len  = midi_data_len(rx_byte_i);
  end

endmodule

// File: rtl/midi_msg_assembler.sv
// Frames received MIDI bytes into 24-bit {status,d1,d2} messages, tracking
// running status, skipping SysEx payloads and passing realtime bytes through.
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter bit REALTIME_EN = 1'b1,
  parameter bit VEL0_TO_OFF = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_RDY,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY,
  output logic        ERR
);

  midi_class_t cls_s;
  midi_state_e state_q;
  logic [7:0]  run_q;
  logic [7:0]  stat_q;
  logic [1:0]  stat_len_q;
  logic [7:0]  d1_q;
  logic [23:0] msg_q;
  logic        rdy_q;
  logic        err_q;
  logic [23:0] one_s;
  logic [23:0] run_one_s;
  logic [23:0] two_s;

  midi_status_class u_class (
    .rx_byte_i (RX_DATA),
    .class_o   (cls_s)
  );

  // Candidate messages for the three ways a data byte can complete one.
  always_comb begin
    one_s     = {stat_q, RX_DATA, 8'h00};
    run_one_s = {run_q, RX_DATA, 8'h00};
    if (VEL0_TO_OFF && (stat_q[7:4] == 4'h9) && (RX_DATA == 8'h00)) begin
      two_s = {NOTE_OFF | {4'h0, stat_q[3:0]}, d1_q, 8'h00};
    end else begin
      two_s = {stat_q, d1_q, RX_DATA};
    end
  end

  // Framing FSM with registered message, strobe and error outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      run_q      <= 8'h00;
      stat_q     <= 8'h00;
      stat_len_q <= 2'd0;
      d1_q       <= 8'h00;
      msg_q      <= 24'h000000;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      if (RX_RDY) begin
        if (cls_s.is_rt) begin
          // Realtime bytes never disturb framing state.
          if (REALTIME_EN) begin
            msg_q <= {RX_DATA, 16'h0000};
            rdy_q <= 1'b1;
          end
        end else if (cls_s.is_chan) begin
          run_q      <= RX_DATA;
          stat_q     <= RX_DATA;
          stat_len_q <= cls_s.data_len;
          state_q    <= WAIT_D1;
        end else if (cls_s.is_common) begin
          run_q <= 8'h00;
          case (RX_DATA)
            SYSEX_START: state_q <= SYSEX;
            8'hF1, 8'hF2, 8'hF3: begin
              stat_q     <= RX_DATA;
              stat_len_q <= cls_s.data_len;
              state_q    <= WAIT_D1;
            end
            TUNE_REQ: begin
              msg_q   <= {TUNE_REQ, 16'h0000};
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end else if (cls_s.is_data) begin
          case (state_q)
            IDLE: begin
              if (run_q != 8'h00) begin
                stat_q     <= run_q;
                stat_len_q <= midi_data_len(run_q);
                d1_q       <= RX_DATA;
                if (midi_data_len(run_q) == 2'd1) begin
                  msg_q <= run_one_s;
                  rdy_q <= 1'b1;
                end else begin
                  state_q <= WAIT_D2;
                end
              end else begin
                err_q <= 1'b1;
              end
            end
            WAIT_D1: begin
              d1_q <= RX_DATA;
              if (stat_len_q == 2'd1) begin
                msg_q   <= one_s;
                rdy_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              msg_q   <= two_s;
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end
            SYSEX:   state_q <= SYSEX;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign MIDI_MSG     = msg_q;
  assign MIDI_MSG_RDY = rdy_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Bench for midi_msg_assembler: two configurations driven in parallel and
// checked every cycle against a byte-list model of MIDI framing.
module tb_midi_msg_assembler;

  logic        clk;
  logic        nrst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [23:0] msg1, msg0;
  logic        rdy1, rdy0, err1, err0;

  int n_checks = 0;
  int n_err    = 0;
  logic compare_en = 1'b0;

  // cfg 1: realtime forwarded, vel0 rewrite on; cfg 0: both off
  logic [7:0]  rs_m   [2];
  logic [7:0]  bf_m   [2][3];
  int          cnt_m  [2];
  logic        sx_m   [2];
  int          errs_m [2];
  logic        pend_rdy [2];
  logic        pend_err [2];
  logic [23:0] pend_msg [2];
  logic        exp_rdy  [2];
  logic        exp_err  [2];
  logic [23:0] exp_msg  [2];
  logic [23:0] log1_q[$];
  logic [23:0] log0_q[$];

  midi_msg_assembler #(.REALTIME_EN(1'b1), .VEL0_TO_OFF(1'b1)) dut1 (
    .CLK(clk), .nRST(nrst), .RX_DATA(rx_data), .RX_RDY(rx_rdy),
    .MIDI_MSG(msg1), .MIDI_MSG_RDY(rdy1), .ERR(err1)
  );

  midi_msg_assembler #(.REALTIME_EN(1'b0), .VEL0_TO_OFF(1'b0)) dut0 (
    .CLK(clk), .nRST(nrst), .RX_DATA(rx_data), .RX_RDY(rx_rdy),
    .MIDI_MSG(msg0), .MIDI_MSG_RDY(rdy0), .ERR(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mlen(input logic [7:0] s);
    if ((s >= 8'h80 && s < 8'hC0) || (s >= 8'hE0 && s < 8'hF0) || s == 8'hF2) return 2;
    if ((s >= 8'hC0 && s < 8'hE0) || s == 8'hF1 || s == 8'hF3) return 1;
    return 0;
  endfunction

  task automatic emit(input int c, input logic [23:0] m);
    pend_rdy[c] = 1'b1;
    pend_msg[c] = m;
    if (c == 1) log1_q.push_back(m);
    else        log0_q.push_back(m);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      rs_m[c] = 8'h00; cnt_m[c] = 0; sx_m[c] = 1'b0;
      pend_rdy[c] = 1'b0; pend_err[c] = 1'b0; pend_msg[c] = 24'h0;
    end
  endtask

  // Message = status byte followed by mlen(status) data bytes.
  task automatic model_byte(input logic [7:0] b);
    for (int c = 0; c < 2; c++) begin
      pend_rdy[c] = 1'b0;
      pend_err[c] = 1'b0;
      if (b >= 8'hF8) begin
        if (c == 1) emit(c, {b, 16'h0});
      end else if (b >= 8'hF0) begin
        rs_m[c] = 8'h00; cnt_m[c] = 0; sx_m[c] = (b == 8'hF0);
        if (b inside {8'hF1, 8'hF2, 8'hF3}) begin bf_m[c][0] = b; cnt_m[c] = 1; end
        else if (b == 8'hF6) emit(c, {b, 16'h0});
      end else if (b >= 8'h80) begin
        rs_m[c] = b; bf_m[c][0] = b; cnt_m[c] = 1; sx_m[c] = 1'b0;
      end else if (!sx_m[c]) begin
        if (cnt_m[c] == 0) begin
          if (rs_m[c] != 8'h00) begin bf_m[c][0] = rs_m[c]; cnt_m[c] = 1; end
          else begin pend_err[c] = 1'b1; errs_m[c]++; end
        end
        if (cnt_m[c] > 0) begin
          bf_m[c][cnt_m[c]] = b;
          cnt_m[c]++;
          if (cnt_m[c] == 1 + mlen(bf_m[c][0])) begin
            if (cnt_m[c] == 2) emit(c, {bf_m[c][0], b, 8'h00});
            else if (c == 1 && bf_m[c][0][7:4] == 4'h9 && b == 8'h00)
              emit(c, {4'h8, bf_m[c][0][3:0], bf_m[c][1], 8'h00});
            else emit(c, {bf_m[c][0], bf_m[c][1], b});
            cnt_m[c] = 0;
          end
        end
      end
    end
  endtask

  // Expectations for the cycle after the byte was presented.
  always @(posedge clk or negedge nrst) begin
    for (int c = 0; c < 2; c++) begin
      if (!nrst) begin
        exp_rdy[c] <= 1'b0; exp_err[c] <= 1'b0; exp_msg[c] <= 24'h0;
      end else begin
        exp_rdy[c] <= pend_rdy[c];
        exp_err[c] <= pend_err[c];
        if (pend_rdy[c]) exp_msg[c] <= pend_msg[c];
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      chk("rdy_cfg1", {23'h0, rdy1}, {23'h0, exp_rdy[1]});
      chk("err_cfg1", {23'h0, err1}, {23'h0, exp_err[1]});
      chk("msg_cfg1", msg1, exp_msg[1]);
      chk("rdy_cfg0", {23'h0, rdy0}, {23'h0, exp_rdy[0]});
      chk("err_cfg0", {23'h0, err0}, {23'h0, exp_err[0]});
      chk("msg_cfg0", msg0, exp_msg[0]);
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_rdy = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_rdy = 1'b0; rx_data = 8'h00;
      for (int c = 0; c < 2; c++) begin pend_rdy[c] = 1'b0; pend_err[c] = 1'b0; end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    nrst = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    model_reset();
    @(negedge clk);
    chk("reset_msg", msg1, 24'h0);
    chk("reset_rdy", {23'h0, rdy1}, 24'h0);
    chk("reset_err", {23'h0, err1}, 24'h0);
    chk("reset_msg0", msg0, 24'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic send_list(input logic [7:0] l [], input int n);
    for (int i = 0; i < n; i++) send(l[i]);
    idle(2);
  endtask

  int b1, b0, e1;
  logic [7:0] seq [];

  initial begin
    nrst = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    errs_m[0] = 0; errs_m[1] = 0;
    model_reset();
    for (int c = 0; c < 2; c++) begin exp_rdy[c] = 1'b0; exp_err[c] = 1'b0; exp_msg[c] = 24'h0; end
    repeat (2) @(posedge clk);
    do_reset();
    compare_en = 1'b1;

    b1 = log1_q.size();
    seq = '{8'h90, 8'h3C, 8'h64};
    send_list(seq, 3);
    chk("t1_count", log1_q.size() - b1, 24'd1);
    chk("t1_msg", log1_q[b1], 24'h903C64);

    b1 = log1_q.size(); b0 = log0_q.size();
    seq = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50, 8'h40, 8'h00};
    send_list(seq, 7);
    chk("t2_msg0", log1_q[b1], 24'h903C64);
    chk("t2_msg1", log1_q[b1 + 1], 24'h903E50);
    chk("t2_vel0", log1_q[b1 + 2], 24'h804000);
    chk("t2_novel0", log0_q[b0 + 2], 24'h904000);

    b1 = log1_q.size(); b0 = log0_q.size();
    seq = '{8'h90, 8'h3C, 8'hF8, 8'h64};
    send_list(seq, 4);
    chk("t3_rt", log1_q[b1], 24'hF80000);
    chk("t3_note", log1_q[b1 + 1], 24'h903C64);
    chk("t3_cfg0_count", log0_q.size() - b0, 24'd1);
    chk("t3_cfg0_note", log0_q[b0], 24'h903C64);

    b1 = log1_q.size(); e1 = errs_m[1];
    seq = '{8'hC5, 8'h07, 8'h08, 8'hF1, 8'h10, 8'h22};
    send_list(seq, 6);
    chk("t4_prog0", log1_q[b1], 24'hC50700);
    chk("t4_prog1", log1_q[b1 + 1], 24'hC50800);
    chk("t4_mtc", log1_q[b1 + 2], 24'hF11000);
    chk("t4_err", errs_m[1] - e1, 24'd1);

    b1 = log1_q.size(); e1 = errs_m[1];
    seq = '{8'hF0, 8'h7E, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h80, 8'h3C, 8'h00};
    send_list(seq, 9);
    chk("t5_count", log1_q.size() - b1, 24'd1);
    chk("t5_off", log1_q[b1], 24'h803C00);
    chk("t5_err", errs_m[1] - e1, 24'd1);

    b1 = log1_q.size();
    seq = '{8'hF6, 8'hFF, 8'hB1, 8'h07, 8'hFA, 8'h7F};
    send_list(seq, 6);
    chk("t6_tune", log1_q[b1], 24'hF60000);
    chk("t6_rt", log1_q[b1 + 1], 24'hFF0000);
    chk("t6_cc", log1_q[b1 + 3], 24'hB1077F);

    b1 = log1_q.size(); e1 = errs_m[1];
    send(8'h90); send(8'h3C);
    do_reset();
    seq = '{8'h64};
    send_list(seq, 1);
    chk("t7_no_emit", log1_q.size() - b1, 24'd0);
    chk("t7_err", errs_m[1] - e1, 24'd1);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
